// File: rtl/multi_cu_thread_dispatcher_pkg.sv
// Shared types for the multi-CU thread dispatcher: payload widths, FSM states, allocate request.
package bgpu_dispatch_pkg;
    localparam int PC_W       = 16;
    localparam int ADDR_W     = 32;
    localparam int TBLK_IDX_W = 5;
    localparam int TGID_W     = 8;

    typedef logic [PC_W-1:0]       pc_t;
    typedef logic [ADDR_W-1:0]     addr_t;
    typedef logic [TBLK_IDX_W-1:0] tblock_idx_t;
    typedef logic [TBLK_IDX_W:0]   tblock_cnt_t;
    typedef logic [TGID_W-1:0]     tgroup_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_WAIT,
        ST_DONE
    } disp_state_e;

    typedef struct packed {
        pc_t         pc;
        addr_t       dp_addr;
        tblock_idx_t tblock_idx;
        tgroup_id_t  tgroup_id;
    } warp_req_t;
endpackage

// File: rtl/multi_cu_thread_dispatcher_arb.sv
// Round-robin pick of the first free compute unit at or above the pointer, wrapping at NumCus.
module rr_free_arbiter #(
    parameter int NumCus = 4,
    localparam int PtrW  = (NumCus > 1) ? $clog2(NumCus) : 1
) (
    input  logic [NumCus-1:0] warp_free_i,
    input  logic              enable_i,
    input  logic [PtrW-1:0]   ptr_i,
    output logic [NumCus-1:0] grant_o,
    output logic [PtrW-1:0]   grant_idx_o,
    output logic              grant_vld_o
);
    int unsigned w_cand;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        w_cand      = 0;
        for (int i = 0; i < NumCus; i++) begin
            w_cand = (int'(ptr_i) + i) % NumCus;
            if (enable_i && !grant_vld_o && warp_free_i[w_cand]) begin
                grant_vld_o     = 1'b1;
                grant_o[w_cand] = 1'b1;
                grant_idx_o     = PtrW'(w_cand);
            end
        end
    end
endmodule

// File: rtl/multi_cu_thread_dispatcher.sv
// Dispatches one thread group's blocks round-robin over NumCus CUs and tracks their completion.
// Optional MULTI_CU_DISPATCHER_PERF_EN adds saturating busy/stall cycle counters.
module multi_cu_thread_dispatcher
    import bgpu_dispatch_pkg::*;
#(
    parameter int PcWidth       = PC_W,
    parameter int AddressWidth  = ADDR_W,
    parameter int TblockIdxBits = TBLK_IDX_W,
    parameter int TgroupIdBits  = TGID_W,
    parameter int NumCus        = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     ready_o,
    input  logic                     start_i,
    input  logic [PcWidth-1:0]       pc_i,
    input  logic [AddressWidth-1:0]  dp_addr_i,
    input  logic [TblockIdxBits:0]   number_of_tblocks_i,
    input  logic [TgroupIdBits-1:0]  tgroup_id_i,
    input  logic [NumCus-1:0]        warp_free_i,
    output logic [NumCus-1:0]        allocate_warp_o,
    output logic [PcWidth-1:0]       allocate_pc_o,
    output logic [AddressWidth-1:0]  allocate_dp_addr_o,
    output logic [TblockIdxBits-1:0] allocate_tblock_idx_o,
    output logic [TgroupIdBits-1:0]  allocate_tgroup_id_o,
    input  logic [NumCus-1:0]        tblock_done_i,
    output logic                     tgroup_done_o,
    output logic [TgroupIdBits-1:0]  tgroup_done_id_o
`ifdef MULTI_CU_DISPATCHER_PERF_EN
    ,
    output logic [31:0]              stall_cycles_o,
    output logic [31:0]              busy_cycles_o
`endif
);
    localparam int PtrW = (NumCus > 1) ? $clog2(NumCus) : 1;
    localparam int SumW = TblockIdxBits + 1 + $clog2(NumCus + 1);

    disp_state_e r_state;
    logic        r_ready, r_done;
    pc_t         r_pc;
    addr_t       r_dp_addr;
    tgroup_id_t  r_tgid;
    tblock_cnt_t r_count, r_next_idx, r_done_cnt;
    logic [PtrW-1:0] r_rr_ptr;

    logic [NumCus-1:0] w_grant;
    logic [PtrW-1:0]   w_grant_idx, w_next_ptr;
    logic              w_alloc, w_counting, w_all_done, w_last_issue;
    logic [SumW-1:0]   w_pop, w_done_sum;
    warp_req_t         w_req;

    rr_free_arbiter #(.NumCus(NumCus)) u_arb (
        .warp_free_i (warp_free_i),
        .enable_i    (r_state == ST_DISPATCH),
        .ptr_i       (r_rr_ptr),
        .grant_o     (w_grant),
        .grant_idx_o (w_grant_idx),
        .grant_vld_o (w_alloc)
    );

    // Several CUs may retire a block in the same cycle; count every pulse.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NumCus; i++) w_pop = w_pop + SumW'(tblock_done_i[i]);
    end

    assign w_counting   = (r_state == ST_DISPATCH) || (r_state == ST_WAIT);
    assign w_done_sum   = SumW'(r_done_cnt) + w_pop;
    assign w_all_done   = w_counting && (w_done_sum >= SumW'(r_count));
    assign w_last_issue = w_alloc && (r_next_idx == r_count - 1'b1);
    assign w_next_ptr   = (w_grant_idx == PtrW'(NumCus - 1)) ? '0 : w_grant_idx + 1'b1;

    assign w_req = '{pc: r_pc, dp_addr: r_dp_addr,
                     tblock_idx: tblock_idx_t'(r_next_idx), tgroup_id: r_tgid};

    assign ready_o               = r_ready;
    assign allocate_warp_o       = w_grant;
    assign allocate_pc_o         = w_req.pc;
    assign allocate_dp_addr_o    = w_req.dp_addr;
    assign allocate_tblock_idx_o = w_req.tblock_idx;
    assign allocate_tgroup_id_o  = w_req.tgroup_id;
    assign tgroup_done_o         = r_done;
    assign tgroup_done_id_o      = r_tgid;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_pc       <= '0;
            r_dp_addr  <= '0;
            r_tgid     <= '0;
            r_count    <= '0;
            r_next_idx <= '0;
            r_done_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) begin
                    r_pc       <= pc_i;
                    r_dp_addr  <= dp_addr_i;
                    r_tgid     <= tgroup_id_i;
                    r_count    <= number_of_tblocks_i;
                    r_next_idx <= '0;
                    r_done_cnt <= '0;
                    r_ready    <= 1'b0;
                    if (number_of_tblocks_i == '0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_DISPATCH;
                    end
                end
                ST_DISPATCH, ST_WAIT: begin
                    if (w_alloc) begin
                        r_next_idx <= r_next_idx + 1'b1;
                        r_rr_ptr   <= w_next_ptr;
                    end
                    r_done_cnt <= w_all_done ? r_count : tblock_cnt_t'(w_done_sum);
                    // Completion wins so a last block finishing as it issues skips WAIT.
                    if (w_all_done) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else if (w_last_issue) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (w_counting || tblock_done_i == '0);
            assert (!w_counting || w_done_sum <= SumW'(r_count));
        end
    end

`ifdef MULTI_CU_DISPATCHER_PERF_EN
    logic [31:0] r_stall_cycles, r_busy_cycles;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cycles <= '0;
            r_busy_cycles  <= '0;
        end else begin
            if (r_state != ST_IDLE && r_busy_cycles != '1)
                r_busy_cycles <= r_busy_cycles + 1'b1;
            if (r_state == ST_DISPATCH && warp_free_i == '0 && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
    assign busy_cycles_o  = r_busy_cycles;
`endif
endmodule
